// File: rtl/comb_sweep_ctrl_if.sv
// comb_sweep_ctrl_if: buttons, datapath and result bus of the sweep controller.
interface comb_sweep_ctrl_if #(
    parameter int KEY_W = 2,
    parameter int LED_W = 10
);
    logic             start;
    logic             hold;
    logic [KEY_W-1:0] code_o;
    logic [LED_W-1:0] res_i;
    logic [LED_W-1:0] res_o;
    logic             res_valid;
    logic [KEY_W-1:0] res_code;
    logic [LED_W-1:0] sig_o;
    logic             busy;
    logic             done;

    modport slave (
        input  start, hold, res_i,
        output code_o, res_o, res_valid, res_code, sig_o, busy, done
    );
    modport master (
        output start, hold, res_i,
        input  code_o, res_o, res_valid, res_code, sig_o, busy, done
    );
endinterface

// File: rtl/comb_sweep_ctrl.sv
// comb_sweep_ctrl: steps a combinational datapath through all input codes and folds
// each settled result into a rotate-XOR signature.
module comb_sweep_ctrl #(
    parameter int KEY_W = 2,
    parameter int LED_W = 10,
    parameter int DWELL = 4
) (
    input logic                clk,
    input logic                rst_n,
    comb_sweep_ctrl_if.slave   bus
);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [KEY_W-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.start ? SETTLE : IDLE;
            SETTLE:  state_n = (!bus.hold && cnt == '0) ? CAPTURE : SETTLE;
            CAPTURE: state_n = (bus.code_o == MAX) ? DONE : SETTLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            bus.code_o    <= '0;
            bus.res_o     <= '0;
            bus.res_code  <= '0;
            bus.sig_o     <= '0;
            bus.res_valid <= 1'b0;
        end else begin
            bus.res_valid <= (state == CAPTURE);
            if (state == IDLE && bus.start) begin
                bus.code_o <= '0;
                cnt        <= CW'(DWELL - 1);
                bus.sig_o  <= '0;
            end
            if (state == SETTLE && !bus.hold && cnt != '0)
                cnt <= cnt - 1'b1;
            if (state == CAPTURE) begin
                bus.res_o    <= bus.res_i;
                bus.res_code <= bus.code_o;
                bus.sig_o    <= {bus.sig_o[LED_W-2:0], bus.sig_o[LED_W-1]} ^ bus.res_i;
                if (bus.code_o != MAX) begin
                    bus.code_o <= bus.code_o + 1'b1;
                    cnt        <= CW'(DWELL - 1);
                end
            end
        end
    end

    // Status is decoded straight from the state register, so it never glitches on res_i.
    assign bus.busy = (state == SETTLE) || (state == CAPTURE);
    assign bus.done = (state == DONE);
endmodule

// File: tb/tb_comb_sweep_ctrl.sv
// tb_comb_sweep_ctrl: directed sweeps with a scoreboard of expected captures and done pulses,
// checked by an independent negedge monitor.
module tb_comb_sweep_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic const_mode;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;

    typedef struct {
        logic [1:0] code;
        logic [9:0] res;
        logic [9:0] sig;
        int         t;
    } exp_t;

    exp_t sbq[$];
    int   done_q[$];
    exp_t cur;
    int   dcur;

    comb_sweep_ctrl_if #(.KEY_W(2), .LED_W(10)) bus ();

    comb_sweep_ctrl #(.KEY_W(2), .LED_W(10), .DWELL(4)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb bus.res_i = const_mode ? 10'h001 : (10'h001 << bus.code_o);

    localparam logic [3:0][9:0] OH_R = {10'h008, 10'h004, 10'h002, 10'h001};
    localparam logic [3:0][9:0] OH_S = {10'h000, 10'h004, 10'h000, 10'h001};
    localparam logic [3:0][9:0] C_R  = {10'h001, 10'h001, 10'h001, 10'h001};
    localparam logic [3:0][9:0] C_S  = {10'h00F, 10'h007, 10'h003, 10'h001};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic chk_zero(input string name);
        chk(name, {5'd0, bus.code_o, bus.res_o, bus.res_code, bus.sig_o,
                   bus.res_valid, bus.busy, bus.done}, 32'd0);
    endtask

    // Captures and done are observed at the negedge following edge t.
    task automatic push_sweep(input int e0, input logic [3:0][9:0] rs, input logic [3:0][9:0] ss,
                              input int hk, input int hd);
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            e.code = 2'(k);
            e.res  = rs[k];
            e.sig  = ss[k];
            e.t    = e0 + (k + 1) * 5 + ((k >= hk) ? hd : 0);
            sbq.push_back(e);
        end
        done_q.push_back(e0 + 20 + hd);
    endtask

    task automatic start_pulse(output int e0);
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        bus.start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sbq.size() != 0 || done_q.size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk(name, 32'(sbq.size() + done_q.size()), 32'd0);
        chk({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.res_valid) begin
                if (sbq.size() == 0) chk("unexpected_res_valid", 32'd1, 32'd0);
                else begin
                    cur = sbq.pop_front();
                    chk("res_code", {30'd0, bus.res_code}, {30'd0, cur.code});
                    chk("res_o", {22'd0, bus.res_o}, {22'd0, cur.res});
                    chk("sig_o", {22'd0, bus.sig_o}, {22'd0, cur.sig});
                    chk("res_time", 32'(cyc), 32'(cur.t));
                end
            end
            if (bus.done) begin
                if (done_q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
                else begin
                    dcur = done_q.pop_front();
                    chk("done_time", 32'(cyc), 32'(dcur));
                    chk("done_busy", {31'd0, bus.busy}, 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int e0;
        rst_n      = 1'b0;
        const_mode = 1'b0;
        bus.start  = 1'($urandom);
        bus.hold   = 1'($urandom);
        repeat (3) @(posedge clk);
        #1 chk_zero("reset_outputs");
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk_zero("idle_20_cycles");

        start_pulse(e0);
        push_sweep(e0, OH_R, OH_S, 4, 0);
        wait_drain("onehot_sweep");

        const_mode = 1'b1;
        start_pulse(e0);
        push_sweep(e0, C_R, C_S, 4, 0);
        wait_drain("const_sweep");
        const_mode = 1'b0;

        start_pulse(e0);
        push_sweep(e0, OH_R, OH_S, 2, 7);
        repeat (11) @(posedge clk);
        #1 bus.hold = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk);
            #1 chk("hold_code", {30'd0, bus.code_o}, 32'd2);
        end
        bus.hold = 1'b0;
        wait_drain("hold_sweep");

        start_pulse(e0);
        push_sweep(e0, OH_R, OH_S, 4, 0);
        repeat (12) @(posedge clk);
        #1 chk("abort_code", {30'd0, bus.code_o}, 32'd2);
        rst_n = 1'b0;
        #1 chk_zero("abort_reset");
        sbq.delete();
        done_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1 chk_zero("abort_no_done");
        start_pulse(e0);
        push_sweep(e0, OH_R, OH_S, 4, 0);
        wait_drain("after_abort_sweep");

        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 e0 = cyc;
        push_sweep(e0, OH_R, OH_S, 4, 0);
        push_sweep(e0 + 22, OH_R, OH_S, 4, 0);
        push_sweep(e0 + 44, OH_R, OH_S, 4, 0);
        repeat (58) @(posedge clk);
        #1 bus.start = 1'b0;
        wait_drain("back_to_back");
        repeat (10) @(posedge clk);
        #1 chk("idle_after_b2b", {31'd0, bus.busy}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
